// File: rtl/sample_packer_if.sv
`default_nettype none
// ============================================================================
// sample_packer_if : sample-in / packed-word-out bundle for sample_packer
// Rev 1.0
// ============================================================================
interface sample_packer_if #(
    parameter int DATA_W = 8,
    parameter int PACK_N = 4,
    parameter int CNT_W  = 8
);
    localparam int CNT_BITS = $clog2(PACK_N + 1);

    logic                       valid_i;
    logic [DATA_W-1:0]          data_i;
    logic                       flush_i;
    logic                       valid_o;
    logic                       ready_i;
    logic [PACK_N*DATA_W-1:0]   data_o;
    logic [CNT_BITS-1:0]        count_o;
    logic                       overflow_o;
    logic [CNT_W-1:0]           drop_cnt_o;

    modport slave (
        input  valid_i, data_i, flush_i, ready_i,
        output valid_o, data_o, count_o, overflow_o, drop_cnt_o
    );

    modport master (
        output valid_i, data_i, flush_i, ready_i,
        input  valid_o, data_o, count_o, overflow_o, drop_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/sample_packer.sv
`default_nettype none
// ============================================================================
// sample_packer : packs PACK_N samples LSB-first into one word on valid/ready
// Rev 1.0
// ============================================================================
module sample_packer #(
    parameter int DATA_W = 8,
    parameter int PACK_N = 4,
    parameter int CNT_W  = 8
) (
    input  logic             slow_clk,
    input  logic             rst,
    sample_packer_if.slave   bus
);
    localparam int               CW         = $clog2(PACK_N + 1);
    localparam int               WW         = PACK_N * DATA_W;
    localparam logic [CW-1:0]    c_CNT_FULL = CW'(PACK_N);

    logic [WW-1:0]      acc_data_q, acc_data_d;
    logic [CW-1:0]      acc_cnt_q, acc_cnt_d;
    logic               flush_pend_q, flush_pend_d;
    logic               valid_q, valid_d;
    logic [WW-1:0]      data_q, data_d;
    logic [CW-1:0]      count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   drop_q, drop_d;

    logic               w_out_free;
    logic               w_acc_full;
    logic               w_flush;
    logic [CW-1:0]      w_cnt_next;
    logic [WW-1:0]      w_acc_wr;

    // Slots above acc_cnt are always zero, so a partial emit needs no masking.
    always_comb begin
        w_acc_wr = acc_data_q;
        for (int k = 0; k < PACK_N; k++) begin
            if (acc_cnt_q == CW'(k)) begin
                w_acc_wr[k*DATA_W +: DATA_W] = bus.data_i;
            end
        end
    end

    always_comb begin
        w_out_free   = !valid_q || bus.ready_i;
        w_acc_full   = (acc_cnt_q == c_CNT_FULL);
        w_flush      = flush_pend_q || bus.flush_i;
        w_cnt_next   = acc_cnt_q + 1'b1;

        acc_data_d   = acc_data_q;
        acc_cnt_d    = acc_cnt_q;
        flush_pend_d = w_flush;
        valid_d      = valid_q && !bus.ready_i;
        data_d       = data_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        drop_d       = drop_q;

        if (w_acc_full && w_out_free) begin
            valid_d      = 1'b1;
            data_d       = acc_data_q;
            count_d      = c_CNT_FULL;
            flush_pend_d = 1'b0;
            if (bus.valid_i) begin
                acc_data_d = {{(WW-DATA_W){1'b0}}, bus.data_i};
                acc_cnt_d  = CW'(1);
            end else begin
                acc_data_d = '0;
                acc_cnt_d  = '0;
            end
        end else if (bus.valid_i && !w_acc_full) begin
            if (w_out_free && ((w_cnt_next == c_CNT_FULL) || w_flush)) begin
                valid_d      = 1'b1;
                data_d       = w_acc_wr;
                count_d      = w_cnt_next;
                flush_pend_d = 1'b0;
                acc_data_d   = '0;
                acc_cnt_d    = '0;
            end else begin
                acc_data_d   = w_acc_wr;
                acc_cnt_d    = w_cnt_next;
            end
        end else if (bus.valid_i) begin
            ovf_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + 1'b1;
            end
        end else if (w_flush) begin
            // A full stalled accumulator keeps the request until the full-word emit.
            if (acc_cnt_q == '0) begin
                flush_pend_d = 1'b0;
            end else if (w_out_free) begin
                valid_d      = 1'b1;
                data_d       = acc_data_q;
                count_d      = acc_cnt_q;
                flush_pend_d = 1'b0;
                acc_data_d   = '0;
                acc_cnt_d    = '0;
            end
        end
    end

    always_ff @(posedge slow_clk) begin
        if (rst) begin
            acc_data_q   <= '0;
            acc_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            drop_q       <= '0;
        end else begin
            acc_data_q   <= acc_data_d;
            acc_cnt_q    <= acc_cnt_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            drop_q       <= drop_d;
        end
    end

    assign bus.valid_o    = valid_q;
    assign bus.data_o     = data_q;
    assign bus.count_o    = count_q;
    assign bus.overflow_o = ovf_q;
    assign bus.drop_cnt_o = drop_q;
endmodule
`default_nettype wire

// File: tb/tb_sample_packer.sv
`default_nettype none
// ============================================================================
// tb_sample_packer : directed vector table, saturation sequence, random vs model
// Rev 1.0
// ============================================================================
module tb_sample_packer;
    localparam int PN = 4;

    logic slow_clk;
    logic rst;
    logic rst2;
    int   checks   = 0;
    int   failures = 0;

    initial slow_clk = 1'b0;
    always #5 slow_clk = ~slow_clk;

    sample_packer_if #(.DATA_W(8), .PACK_N(PN), .CNT_W(8)) bus ();
    sample_packer_if #(.DATA_W(8), .PACK_N(PN), .CNT_W(2)) bus2 ();

    sample_packer #(.DATA_W(8), .PACK_N(PN), .CNT_W(8)) dut (
        .slow_clk (slow_clk),
        .rst      (rst),
        .bus      (bus)
    );

    sample_packer #(.DATA_W(8), .PACK_N(PN), .CNT_W(2)) dut2 (
        .slow_clk (slow_clk),
        .rst      (rst2),
        .bus      (bus2)
    );

    typedef struct {
        bit          rs;
        bit          v;
        logic [7:0]  d;
        bit          f;
        bit          r;
        bit          ev;
        logic [31:0] ed;
        logic [2:0]  ec;
        bit          eovf;
        logic [7:0]  edrop;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rs, input bit v, input logic [7:0] d, input bit f,
                       input bit r, input bit ev, input logic [31:0] ed,
                       input logic [2:0] ec, input bit eovf, input logic [7:0] edrop);
        vec_t t;
        t.rs = rs; t.v = v; t.d = d; t.f = f; t.r = r;
        t.ev = ev; t.ed = ed; t.ec = ec; t.eovf = eovf; t.edrop = edrop;
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit f, input bit r, input bit rs);
        bus.valid_i = v;
        bus.data_i  = d;
        bus.flush_i = f;
        bus.ready_i = r;
        rst         = rs;
        @(posedge slow_clk);
        #1;
    endtask

    // Reference model: accumulator as a queue of samples, output as a plain word.
    logic [7:0]  macc[$];
    bit          mv, mpend, movf;
    logic [31:0] md;
    int          mc, mdrop;

    function automatic logic [31:0] pack(input logic [7:0] q[$]);
        logic [31:0] w = 32'h0;
        foreach (q[k]) w = w | (32'(q[k]) << (8 * k));
        return w;
    endfunction

    task automatic emit();
        mv = 1'b1;
        md = pack(macc);
        mc = macc.size();
        macc.delete();
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit f, input bit r);
        bit free = !mv || r;
        bit fp   = mpend || f;
        if (mv && r) mv = 1'b0;
        if (macc.size() == PN && free) begin
            emit();
            fp = 1'b0;
            if (v) macc.push_back(d);
        end else if (v && macc.size() < PN) begin
            macc.push_back(d);
            if (free && (macc.size() == PN || fp)) begin
                emit();
                fp = 1'b0;
            end
        end else if (v) begin
            movf = 1'b1;
            if (mdrop < 255) mdrop++;
        end else if (fp) begin
            if (macc.size() == 0) fp = 1'b0;
            else if (free) begin
                emit();
                fp = 1'b0;
            end
        end
        mpend = fp;
    endtask

    initial begin
        logic [44:0] act, exp;
        rst2 = 1'b1;
        bus2.valid_i = 1'b0; bus2.data_i = 8'h0; bus2.flush_i = 1'b0; bus2.ready_i = 1'b0;

        // rs v  d     f r   ev ed            ec ovf drop
        add(1, 0, 8'h00, 0, 1, 0, 32'h0,        0, 0, 0);
        add(0, 1, 8'h11, 0, 1, 0, 32'h0,        0, 0, 0);
        add(0, 1, 8'h22, 0, 1, 0, 32'h0,        0, 0, 0);
        add(0, 1, 8'h33, 0, 1, 0, 32'h0,        0, 0, 0);
        add(0, 1, 8'h44, 0, 1, 1, 32'h44332211, 4, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 32'h0,        0, 0, 0);
        for (int i = 1; i <= 3; i++) add(0, 1, 8'(i), 0, 0, 0, 32'h0, 0, 0, 0);
        for (int i = 4; i <= 8; i++) add(0, 1, 8'(i), 0, 0, 1, 32'h04030201, 4, 0, 0);
        add(0, 1, 8'h09, 0, 0, 1, 32'h04030201, 4, 1, 1);
        add(0, 0, 8'h00, 0, 1, 1, 32'h08070605, 4, 1, 1);
        add(0, 0, 8'h00, 0, 1, 0, 32'h0,        0, 1, 1);
        add(0, 1, 8'hAA, 0, 1, 0, 32'h0,        0, 1, 1);
        add(0, 1, 8'hBB, 0, 1, 0, 32'h0,        0, 1, 1);
        add(0, 0, 8'h00, 1, 1, 1, 32'h0000BBAA, 2, 1, 1);
        add(0, 0, 8'h00, 1, 1, 0, 32'h0,        0, 1, 1);
        add(0, 0, 8'h00, 0, 1, 0, 32'h0,        0, 1, 1);
        add(0, 1, 8'hC1, 0, 0, 0, 32'h0,        0, 1, 1);
        add(0, 1, 8'hC2, 0, 0, 0, 32'h0,        0, 1, 1);
        add(0, 1, 8'hC3, 0, 0, 0, 32'h0,        0, 1, 1);
        add(0, 1, 8'hC4, 0, 0, 1, 32'hC4C3C2C1, 4, 1, 1);
        for (int i = 1; i <= 4; i++) add(0, 1, 8'(8'hD0 + i), 0, 0, 1, 32'hC4C3C2C1, 4, 1, 1);
        add(0, 1, 8'h55, 0, 1, 1, 32'hD4D3D2D1, 4, 1, 1);
        add(0, 1, 8'h66, 0, 1, 0, 32'h0,        0, 1, 1);
        add(0, 1, 8'h77, 0, 1, 0, 32'h0,        0, 1, 1);
        add(0, 1, 8'h88, 0, 1, 1, 32'h88776655, 4, 1, 1);
        add(0, 0, 8'h00, 0, 1, 0, 32'h0,        0, 1, 1);
        add(0, 1, 8'h10, 0, 1, 0, 32'h0,        0, 1, 1);
        add(0, 1, 8'h20, 0, 1, 0, 32'h0,        0, 1, 1);
        add(1, 0, 8'h00, 0, 1, 0, 32'h0,        0, 0, 0);
        add(0, 1, 8'hA1, 0, 1, 0, 32'h0,        0, 0, 0);
        add(0, 1, 8'hA2, 0, 1, 0, 32'h0,        0, 0, 0);
        add(0, 1, 8'hA3, 0, 1, 0, 32'h0,        0, 0, 0);
        add(0, 1, 8'hA4, 0, 1, 1, 32'hA4A3A2A1, 4, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 32'h0,        0, 0, 0);
        add(0, 1, 8'hE1, 0, 1, 0, 32'h0,        0, 0, 0);
        add(0, 1, 8'hE2, 1, 1, 1, 32'h0000E2E1, 2, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 32'h0,        0, 0, 0);

        foreach (tbl[i]) begin
            bit chk;
            drive(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r, tbl[i].rs);
            chk = tbl[i].ev || tbl[i].rs;
            act = {bus.valid_o, bus.overflow_o, bus.drop_cnt_o,
                   chk ? {bus.count_o, bus.data_o} : 35'h0};
            exp = {tbl[i].ev, tbl[i].eovf, tbl[i].edrop,
                   chk ? {tbl[i].ec, tbl[i].ed} : 35'h0};
            check($sformatf("vec%0d", i), 64'(act), 64'(exp));
        end

        // Drop-counter saturation with a 2-bit counter.
        @(posedge slow_clk); #1;
        rst2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus2.valid_i = 1'b1;
            bus2.data_i  = 8'(i);
            @(posedge slow_clk); #1;
        end
        check("sat_nodrop", 64'({bus2.overflow_o, bus2.drop_cnt_o}), 64'(3'b000));
        for (int i = 0; i < 5; i++) begin
            bus2.data_i = 8'(8'h40 + i);
            @(posedge slow_clk); #1;
            if (i == 1) check("sat_two", 64'({bus2.overflow_o, bus2.drop_cnt_o}), 64'(3'b110));
        end
        bus2.valid_i = 1'b0;
        check("sat_final", 64'({bus2.overflow_o, bus2.drop_cnt_o}), 64'(3'b111));
        check("sat_held", 64'({bus2.valid_o, bus2.count_o, bus2.data_o}),
              64'({1'b1, 3'd4, 32'h03020100}));

        // Randomised traffic against the queue model.
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        macc.delete(); mv = 0; mpend = 0; movf = 0; md = 0; mc = 0; mdrop = 0;
        for (int n = 0; n < 3000; n++) begin
            bit          v = ($urandom_range(99) < 60);
            logic [7:0]  d = 8'($urandom);
            bit          f = ($urandom_range(99) < 6);
            bit          r = ($urandom_range(99) < 55);
            drive(v, d, f, r, 1'b0);
            model_step(v, d, f, r);
            act = {bus.valid_o, bus.overflow_o, bus.drop_cnt_o,
                   mv ? {bus.count_o, bus.data_o} : 35'h0};
            exp = {mv, movf, 8'(mdrop), mv ? {3'(mc), md} : 35'h0};
            check($sformatf("rand%0d", n), 64'(act), 64'(exp));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sample_packer.md
Name: sample_packer

Overview:
Slow-domain stage directly downstream of data_sampler. It consumes data_sampler's single-cycle valid_o/data_o pulses and packs PACK_N consecutive samples into one wide word, LSB-first. The packed word is presented on a valid/ready interface to the consumer. A one-word accumulator plus one output register absorb backpressure. Samples that cannot be stored are dropped, flagged and counted.

Parameters:
DATA_W, 8, width of one sample (must match data_sampler DATA_W)
PACK_N, 4, samples per packed word; PACK_N >= 2
CNT_W, 8, width of saturating drop counter

Ports:
slow_clk  in  1  sole clock; all logic is on its rising edge
rst  in  1  synchronous reset, active-high
valid_i  in  1  sample strobe (data_sampler valid_o); no backpressure upstream
data_i  in  DATA_W  sample (data_sampler data_o); sampled only when valid_i=1
flush_i  in  1  request to emit a partial word; one-cycle pulse
valid_o  out  1  packed word available
ready_i  in  1  consumer accepts the word when valid_o && ready_i
data_o  out  PACK_N*DATA_W  packed word; slot k = bits [k*DATA_W +: DATA_W]
count_o  out  $clog2(PACK_N+1)  number of valid slots in data_o (1..PACK_N)
overflow_o  out  1  sticky: at least one sample dropped since reset
drop_cnt_o  out  CNT_W  dropped-sample count, saturates at all-ones

Behaviour:
- Reset, while rst=1 at an edge:
  - valid_o=0, data_o=0, count_o=0, overflow_o=0, drop_cnt_o=0.
  - Accumulator data and count (acc_cnt) are cleared; flush_pend is cleared.
  - A partial or stalled word is discarded. Reset has priority over every other input.
- State: accumulator (PACK_N slots, acc_cnt 0..PACK_N), output register (valid_o/data_o/count_o), flush_pend flag.
- Per-cycle equations:
  - out_free = !valid_o || ready_i.
  - acc_full = (acc_cnt == PACK_N).
- If acc_full && out_free:
  - The accumulator word moves to the output register (count_o = PACK_N).
  - If valid_i=1 in the same cycle, data_i goes to slot 0 of the cleared accumulator (acc_cnt=1). It is not dropped.
- Else, if valid_i && !acc_full:
  - data_i is written to slot acc_cnt; cnt_next = acc_cnt+1.
  - If cnt_next==PACK_N and out_free, the completed word (including data_i) loads the output register directly. Latency from the last sample to valid_o is 1 cycle. The accumulator clears.
- Else, if valid_i && acc_full && !out_free: the sample is dropped.
  - overflow_o <= 1.
  - drop_cnt_o increments, saturating at 2^CNT_W-1.
- Flush:
  - flush_i sets flush_pend.
  - While flush_pend=1, out_free=1 and the effective count (acc_cnt plus any same-cycle accepted sample) is > 0: the accumulator emits with count_o equal to that count. Unused slots are zero. flush_pend clears.
  - A flush_i with effective count 0 clears flush_pend with no output.
  - A flush_i with a same-cycle valid_i includes that sample.
  - A flush pending on a full, stalled accumulator is satisfied by the eventual full-word emit.
- Output handshake:
  - data_o and count_o hold stable while valid_o && !ready_i.
  - When no new word loads, valid_o drops the cycle after a handshake.
  - Back-to-back words are possible with ready_i held at 1.
- Capacity: up to 2*PACK_N samples are held under full stall. The drop occurs on sample 2*PACK_N+1.
- overflow_o and drop_cnt_o clear only on rst.

Test Plan:
(DATA_W=8, PACK_N=4)
- Fill: ready_i=1; samples 0x11,0x22,0x33,0x44 on consecutive cycles -> valid_o=1 one cycle after 0x44 for one cycle, data_o=0x44332211, count_o=4.
- Backpressure and drop: ready_i=0; samples 0x01..0x09 -> valid_o=1 with 0x04030201 held. 0x09 is dropped: overflow_o=1, drop_cnt_o=1. Then ready_i=1 -> 0x04030201, then 0x08070605 on the next cycle.
- Flush: samples 0xAA,0xBB, then flush_i -> data_o=0x0000BBAA, count_o=2. A second flush_i with an empty accumulator -> no valid_o.
- Simultaneous emit and accept: accumulator full, valid_o=1, ready_i=1, valid_i=1 with 0x55 in the same cycle -> no drop. The next word's slot 0 = 0x55, confirmed by feeding 0x66,0x77,0x88 -> 0x88776655.
- Reset mid-word: samples 0x10,0x20, then rst pulse -> all outputs 0. Samples 0xA1..0xA4 -> 0xA4A3A2A1 with count_o=4 and no stale data.
- Drop-counter saturation: CNT_W=2, stalled full buffer, 5 extra samples -> drop_cnt_o=3, overflow_o=1.
